alu_md_seq: RTL
===============

Name: alu_md_seq

Overview:
- Parametrised successor to the single-cycle integer ALU.
- Executes RV32I/RV64I-style ALU ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) behind a valid/ready handshake.
- Base ops take one cycle. Multiply and divide run on an iterative radix-2 core for WIDTH cycles.
- Sits in the EX stage between decode/operand fetch and writeback. Decode stalls on in_ready=0.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  operands and fun valid.
- in_ready  out  1  block can accept an op.
- fun  in  10  {funct3[2:0], funct7[6:0]}; funct7 is 0 for I-type.
- inst_type  in  6  one-hot decode class; bit4 = I-type ALU, bit5 = R-type.
- in1  in  WIDTH  rs1 operand.
- in2  in  WIDTH  rs2 operand or sign-extended immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result, held stable while out_valid=1 and out_ready=0.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, any time, including mid-divide): state = IDLE, out_valid = 0, out = 0, iteration counter = 0, in_ready = 1.
- Outputs by state: in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Accept: in IDLE, on in_valid & in_ready, latch fun, inst_type, in1, in2.

Op select:
- M-op when inst_type[5] and funct7 = 7'h01.
- Otherwise base op by funct3:
  - 0: add, or sub when inst_type[5] & funct7[5].
  - 1: sll.
  - 2: slt (signed).
  - 3: sltu.
  - 4: xor.
  - 5: srl, or sra when (inst_type[4] & in2[11:5]==7'h20) or (inst_type[5] & funct7[5]).
  - 6: or.
  - 7: and.
- Shift amount is in2[SHW-1:0]. slt/sltu return zero-extended 1 or 0.
- Unrecognised funct7 on R-type: result 0, no error.

Timing:
- Base op: computed and registered on the accept edge. State goes to DONE, so out_valid rises one cycle after accept (latency 1).
- M-op: IDLE→BUSY, counter loaded with WIDTH-1. One product/quotient bit per cycle; decrement each cycle. At counter=0, result is registered and state goes to DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE → IDLE on out_ready. The next op can be accepted the cycle after. Throughput is at most one op per 2 cycles; accepted in the same cycle out_ready is seen is not allowed.

Multiply:
- Operate on magnitudes: in1 is signed for MULH and MULHSU; in2 is signed only for MULH.
- Form the 2·WIDTH-bit product, then negate if the signs differ.
- MUL returns the low WIDTH bits. MULH, MULHSU and MULHU return the high WIDTH bits.

Divide:
- Restoring division on magnitudes.
- Quotient is negated if the signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Divide by zero, decided at accept with no iteration (latency 1): quotient = all ones, remainder = in1.
- Signed overflow, in1 = most-negative and in2 = -1 (DIV/REM), also latency 1: quotient = in1, remainder = 0.

Flush:
- Flush has priority over all except rst.
- In BUSY or DONE: state goes to IDLE, out_valid drops next cycle, result is discarded, counter is cleared.
- flush with in_valid in IDLE: the op is not accepted.
- out_valid & out_ready & flush in the same cycle: counts as flushed; the consumer must ignore it.

Decomposition:
- Package alu_pkg:
  - funct3 constants: F3_ADD..F3_AND, F3_MUL..F3_REMU.
  - F7_ALT = 7'h20, F7_MULDIV = 7'h01.
  - Inst-type bit indices: IT_I = 4, IT_R = 5.
  - State enum {IDLE, BUSY, DONE}.
- Sub-module alu_iter_md, the iterative mul/div core:
  - Inputs: start, op, magnitudes.
  - Outputs: done, hi/lo result.
  - Sign fixup stays in the parent.
- Base-op datapath stays inline in the parent.

Test Plan:
- add/sub: funct3=0, in1=5, in2=7, R-type funct7=0 → out=12 at cycle+1. Same op with funct7=0x20 → out=0xFFFFFFFE.
- Shifts: in1=0x80000000, shamt 4. srai (I-type, in2[11:5]=0x20) → 0xF8000000. srli → 0x08000000. Only in2[4:0] is used when in2=0x24 → shift by 4.
- MULH: in1=0xFFFFFFFF (-1), in2=2 → out=0xFFFFFFFF after 33 cycles. MULHU with the same operands → 0x00000001. MUL → 0xFFFFFFFE. in_ready is 0 throughout BUSY.
- DIV edge cases: DIV 7/0 → 0xFFFFFFFF and REM 7/0 → 7, both at cycle+1. DIV 0x80000000/-1 → 0x80000000, REM → 0. DIV -7/2 → -3, REM → -1.
- Backpressure and flush: hold out_ready=0 for 5 cycles after DIVU 100/7 → out stays 14 and out_valid stays 1. Issue a new DIVU, assert flush at BUSY cycle 10 → IDLE and in_ready=1 next cycle, no out_valid.
- Async reset: assert rst mid-MUL between clock edges → out_valid=0 and in_ready=1 immediately. Next op after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants, FSM state type and mul/div core opcode for the
// sequential ALU with M-extension support.
package alu_pkg;

    localparam logic [2:0] F3_ADD    = 3'd0;
    localparam logic [2:0] F3_SLL    = 3'd1;
    localparam logic [2:0] F3_SLT    = 3'd2;
    localparam logic [2:0] F3_SLTU   = 3'd3;
    localparam logic [2:0] F3_XOR    = 3'd4;
    localparam logic [2:0] F3_SR     = 3'd5;
    localparam logic [2:0] F3_OR     = 3'd6;
    localparam logic [2:0] F3_AND    = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam int unsigned IT_I = 4;
    localparam int unsigned IT_R = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        MD_MUL,
        MD_DIV
    } md_op_t;

endpackage

// File: rtl/alu_iter_md.sv
// Iterative radix-2 unsigned multiply (shift-add) and restoring divide core.
// Operates on magnitudes only; sign handling lives in the parent.
module alu_iter_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             busy;
    md_op_t           op_q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum   = '0;
        shl   = '0;
        diff  = '0;
        hi_nx = hi_q;
        lo_nx = lo_q;
        if (op_q == MD_MUL) begin
            sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d} : '0);
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            shl   = {hi_q, lo_q[WIDTH-1]};
            diff  = shl - {1'b0, d};
            hi_nx = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    // The final step is exposed combinationally so the parent registers the
    // finished result on the same edge that retires the last iteration.
    assign done = busy && (cnt == '0);
    assign hi   = hi_nx;
    assign lo   = lo_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
            op_q <= MD_MUL;
            d    <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (kill) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            op_q <= op;
            d    <= b;
            hi_q <= '0;
            lo_q <= a;
            cnt  <= CW'(WIDTH - 1);
            busy <= 1'b1;
        end else if (busy) begin
            hi_q <= hi_nx;
            lo_q <= lo_nx;
            busy <= (cnt != '0);
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_md_seq.sv
// EX-stage ALU: single-cycle base integer ops plus iterative M-extension
// multiply/divide behind valid/ready handshakes on both sides.
module alu_md_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       fun,
    input  logic [5:0]       inst_type,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_nx;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [6:0]         imm_hi;
    logic [SHW-1:0]     shamt;
    logic               is_md;
    logic               md_div;
    logic               sgn1;
    logic               sgn2;
    logic               s1;
    logic               s2;
    logic               div_zero;
    logic               div_ovf;
    logic               accept;
    logic               md_start;
    md_op_t             md_op;
    logic               alt;
    logic               sra;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   base_res;
    logic [WIDTH-1:0]   fast_res;
    logic [WIDTH-1:0]   md_res;
    logic [2*WIDTH-1:0] prod;
    logic [2:0]         f3_q;
    logic               neg_q;
    logic               neg_r;
    logic               core_done;
    logic [WIDTH-1:0]   core_hi;
    logic [WIDTH-1:0]   core_lo;
    logic               unused_inst;

    assign funct3      = fun[9:7];
    assign funct7      = fun[6:0];
    assign shamt       = in2[SHW-1:0];
    assign unused_inst = ^inst_type[3:0];

    if (WIDTH >= 12) begin : g_imm
        assign imm_hi = in2[11:5];
    end else begin : g_imm_narrow
        assign imm_hi = 7'(in2[WIDTH-1:5]);
    end

    assign is_md  = inst_type[IT_R] && (funct7 == F7_MULDIV);
    assign md_div = funct3[2];
    assign md_op  = md_div ? MD_DIV : MD_MUL;

    // Operand signedness: DIV/REM sign both, MULH both, MULHSU only in1.
    always_comb begin
        sgn1     = md_div ? (funct3 == F3_DIV || funct3 == F3_REM)
                          : (funct3 == F3_MULH || funct3 == F3_MULHSU);
        sgn2     = md_div ? sgn1 : (funct3 == F3_MULH);
        s1       = sgn1 && in1[WIDTH-1];
        s2       = sgn2 && in2[WIDTH-1];
        mag1     = s1 ? -in1 : in1;
        mag2     = s2 ? -in2 : in2;
        div_zero = md_div && (in2 == '0);
        div_ovf  = md_div && sgn1 && (in1 == MIN_NEG) && (in2 == '1);
    end

    assign accept   = (state == IDLE) && in_valid && !flush;
    assign md_start = accept && is_md && !(div_zero || div_ovf);

    always_comb begin
        alt      = inst_type[IT_R] && funct7[5];
        sra      = (inst_type[IT_I] && (imm_hi == F7_ALT)) || alt;
        base_res = '0;
        case (funct3)
            F3_ADD:  base_res = alt ? (in1 - in2) : (in1 + in2);
            F3_SLL:  base_res = in1 << shamt;
            F3_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            F3_SLTU: base_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            F3_XOR:  base_res = in1 ^ in2;
            F3_SR: begin
                if (sra) begin
                    base_res = $signed(in1) >>> shamt;
                end else begin
                    base_res = in1 >> shamt;
                end
            end
            F3_OR:   base_res = in1 | in2;
            default: base_res = in1 & in2;
        endcase
        if (inst_type[IT_R] && (funct7 != 7'h00) && (funct7 != F7_ALT)) begin
            base_res = '0;
        end
    end

    always_comb begin
        if (!is_md) begin
            fast_res = base_res;
        end else if (div_zero) begin
            fast_res = funct3[1] ? in1 : '1;
        end else begin
            fast_res = funct3[1] ? '0 : in1;
        end
    end

    always_comb begin
        prod = {core_hi, core_lo};
        if (neg_q) begin
            prod = -prod;
        end
        case (f3_q)
            F3_MUL:                      md_res = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: md_res = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:             md_res = neg_q ? -core_lo : core_lo;
            default:                     md_res = neg_r ? -core_hi : core_hi;
        endcase
    end

    alu_iter_md #(
        .WIDTH(WIDTH)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .kill  (flush),
        .op    (md_op),
        .a     (mag1),
        .b     (mag2),
        .done  (core_done),
        .hi    (core_hi),
        .lo    (core_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nx = md_start ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (core_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                f3_q  <= funct3;
                neg_q <= s1 ^ s2;
                neg_r <= s1;
                if (!md_start) begin
                    out <= fast_res;
                end
            end else if ((state == BUSY) && core_done) begin
                out <= md_res;
            end
        end
    end

endmodule
